// File: rtl/mips_pkg.sv
// Shared datapath widths and the write-port arbiter state type.
package mips_pkg;

   localparam int SIZE       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FORCE = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of MDU results with per-entry live bits, WAW cancel and
// source-register match outputs for the ID-stage interlock.
module wb_result_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [REG_ADDR_W-1:0]  pushRd,
   input  logic [SIZE-1:0]        pushData,
   input  logic                   pop,
   input  logic                   cancelEn,
   input  logic [REG_ADDR_W-1:0]  cancelRd,
   input  logic [REG_ADDR_W-1:0]  rsAddr,
   input  logic [REG_ADDR_W-1:0]  rtAddr,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   headLive,
   output logic [REG_ADDR_W-1:0]  headRd,
   output logic [SIZE-1:0]        headData,
   output logic                   rsMatch,
   output logic                   rtMatch
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_ADDR_W-1:0] rdMem   [DEPTH];
   logic [SIZE-1:0]       dataMem [DEPTH];
   logic [DEPTH-1:0]      live;
   logic [DEPTH-1:0]      liveNext;
   logic [PTR_W-1:0]      wrPtr;
   logic [PTR_W-1:0]      rdPtr;
   logic [CNT_W-1:0]      cnt;

   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign headLive = live[rdPtr];
   assign headRd   = rdMem[rdPtr];
   assign headData = dataMem[rdPtr];

   // Cancel and pop clear first; a same-cycle push is younger and stays live.
   always_comb begin
      liveNext = live;
      for (int i = 0; i < DEPTH; i++) begin
         if (cancelEn && live[i] && (rdMem[i] == cancelRd)) begin
            liveNext[i] = 1'b0;
         end
      end
      if (pop) begin
         liveNext[rdPtr] = 1'b0;
      end
      if (push) begin
         liveNext[wrPtr] = 1'b1;
      end
   end

   always_comb begin
      rsMatch = 1'b0;
      rtMatch = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && (rdMem[i] == rsAddr) && (rsAddr != '0)) begin
            rsMatch = 1'b1;
         end
         if (live[i] && (rdMem[i] == rtAddr) && (rtAddr != '0)) begin
            rtMatch = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
         live  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rdMem[i]   <= '0;
            dataMem[i] <= '0;
         end
      end else begin
         live <= liveNext;
         if (push) begin
            rdMem[wrPtr]   <= pushRd;
            dataMem[wrPtr] <= pushData;
            wrPtr          <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by the WB stage (priority) and queued MDU
// results; a head that waits MAX_WAIT cycles forces a one-cycle pipeline stall.
module wb_port_arbiter
   import mips_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_valid,
   input  logic                  wb_reg_write,
   input  logic                  wb_mem_to_reg,
   input  logic [SIZE-1:0]       wb_read_data,
   input  logic [SIZE-1:0]       wb_alu_result,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  mdu_valid,
   output logic                  mdu_ready,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [SIZE-1:0]       mdu_data,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic                  rs_pending,
   output logic                  rt_pending,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [SIZE-1:0]       rf_wdata,
   output logic                  stall_pipe,
   output wb_state_t             dbgState
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AGE_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT - 1);

   logic                  pipeWr;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      countAfter;
   logic                  headLive;
   logic [REG_ADDR_W-1:0] headRd;
   logic [SIZE-1:0]       headData;
   wb_state_t             state;
   wb_state_t             stateNext;
   logic [AGE_W-1:0]      age;
   logic [AGE_W-1:0]      ageNext;

   // MDU handshake: a result transfers on any cycle with mdu_valid and
   // mdu_ready both high; mdu_ready depends only on occupancy, never on pop.
   assign mdu_ready  = !full;
   assign push       = mdu_valid && !full;
   assign pipeWr     = wb_valid && wb_reg_write && (wb_rd != '0) && !stall_pipe;
   assign pop        = !pipeWr && !empty;
   assign countAfter = count + CNT_W'(push) - CNT_W'(pop);
   assign dbgState   = state;

   wb_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pushRd   (mdu_rd),
      .pushData (mdu_data),
      .pop      (pop),
      .cancelEn (pipeWr),
      .cancelRd (wb_rd),
      .rsAddr   (rs_addr),
      .rtAddr   (rt_addr),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .headLive (headLive),
      .headRd   (headRd),
      .headData (headData),
      .rsMatch  (rs_pending),
      .rtMatch  (rt_pending)
   );

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (pipeWr) begin
         rf_we    = 1'b1;
         rf_waddr = wb_rd;
         rf_wdata = wb_mem_to_reg ? wb_read_data : wb_alu_result;
      end else if (pop) begin
         rf_we    = headLive && (headRd != '0);
         rf_waddr = headRd;
         rf_wdata = headData;
      end
      if (!rst_n) begin
         rf_we = 1'b0;
      end
   end

   // age counts cycles the head sits unpopped; FORCE always pops because WB is blocked.
   always_comb begin
      stateNext = state;
      ageNext   = age;
      case (state)
         IDLE: begin
            if (push) begin
               stateNext = PEND;
               ageNext   = '0;
            end
         end
         PEND: begin
            if (pop) begin
               ageNext = '0;
               if (countAfter == '0) begin
                  stateNext = IDLE;
               end
            end else if (age == AGE_LIMIT) begin
               stateNext = FORCE;
               ageNext   = '0;
            end else begin
               ageNext = age + AGE_W'(1);
            end
         end
         FORCE: begin
            ageNext   = '0;
            stateNext = (countAfter == '0) ? IDLE : PEND;
         end
         default: begin
            stateNext = IDLE;
            ageNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         age        <= '0;
         stall_pipe <= 1'b0;
      end else begin
         state      <= stateNext;
         age        <= ageNext;
         stall_pipe <= (stateNext == FORCE);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a queue-based
// reference model of the write-port sharing rules.
module tb_wb_port_arbiter;
   import mips_pkg::*;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  wb_valid;
   logic                  wb_reg_write;
   logic                  wb_mem_to_reg;
   logic [SIZE-1:0]       wb_read_data;
   logic [SIZE-1:0]       wb_alu_result;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  mdu_valid;
   logic                  mdu_ready;
   logic [REG_ADDR_W-1:0] mdu_rd;
   logic [SIZE-1:0]       mdu_data;
   logic [REG_ADDR_W-1:0] rs_addr;
   logic [REG_ADDR_W-1:0] rt_addr;
   logic                  rs_pending;
   logic                  rt_pending;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [SIZE-1:0]       rf_wdata;
   logic                  stall_pipe;
   wb_state_t             dbgState;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_read_data  (wb_read_data),
      .wb_alu_result (wb_alu_result),
      .wb_rd         (wb_rd),
      .mdu_valid     (mdu_valid),
      .mdu_ready     (mdu_ready),
      .mdu_rd        (mdu_rd),
      .mdu_data      (mdu_data),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rs_pending    (rs_pending),
      .rt_pending    (rt_pending),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .stall_pipe    (stall_pipe),
      .dbgState      (dbgState)
   );

   // ---------------- reference model / scoreboard ----------------
   // exp_q entry = {live, rd, data}; oldest result at the front.
   logic [37:0]     exp_q[$];
   int              blocked;
   logic            stallExp;
   logic [SIZE-1:0] modelRf  [32];
   logic [SIZE-1:0] shadowRf [32];
   logic            curPipeWr;
   logic            curPop;
   logic            shWe;
   logic [4:0]      shAddr;
   logic [SIZE-1:0] shData;
   int              testCount;
   int              failCount;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic modelPending(input logic [4:0] addr);
      logic hit;
      hit = 1'b0;
      foreach (exp_q[i]) begin
         if (exp_q[i][37] && (exp_q[i][36:32] == addr) && (addr != 5'd0)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Compare every output against the model for the inputs currently driven.
   task automatic checkCycle(input string tag);
      logic            expWe;
      logic [4:0]      expAddr;
      logic [SIZE-1:0] expData;
      logic [37:0]     head;
      wb_state_t       expState;
      @(negedge clk);
      curPipeWr = wb_valid && wb_reg_write && (wb_rd != 5'd0) && !stallExp;
      curPop    = !curPipeWr && (exp_q.size() > 0);
      expWe     = 1'b0;
      expAddr   = '0;
      expData   = '0;
      if (curPipeWr) begin
         expWe   = 1'b1;
         expAddr = wb_rd;
         expData = wb_mem_to_reg ? wb_read_data : wb_alu_result;
      end else if (curPop) begin
         head    = exp_q[0];
         expWe   = head[37] && (head[36:32] != 5'd0);
         expAddr = head[36:32];
         expData = head[31:0];
      end
      if (stallExp) expState = FORCE;
      else if (exp_q.size() == 0) expState = IDLE;
      else expState = PEND;
      check($sformatf("%s_stall", tag), stall_pipe, stallExp);
      check($sformatf("%s_ready", tag), mdu_ready, exp_q.size() < DEPTH);
      check($sformatf("%s_we", tag), rf_we, expWe);
      if (expWe) begin
         check($sformatf("%s_waddr", tag), rf_waddr, expAddr);
         check($sformatf("%s_wdata", tag), rf_wdata, expData);
      end
      check($sformatf("%s_rspend", tag), rs_pending, modelPending(rs_addr));
      check($sformatf("%s_rtpend", tag), rt_pending, modelPending(rt_addr));
      check($sformatf("%s_state", tag), dbgState, expState);
      shWe   = rf_we;
      shAddr = rf_waddr;
      shData = rf_wdata;
   endtask

   // Clock edge: apply the WB write / cancel, the pop, the push and the wait rule.
   task automatic advance();
      int          sizeBefore;
      logic        readyBefore;
      logic [37:0] e;
      @(posedge clk);
      sizeBefore  = exp_q.size();
      readyBefore = sizeBefore < DEPTH;
      if (shWe) shadowRf[shAddr] = shData;
      if (curPipeWr) begin
         modelRf[wb_rd] = wb_mem_to_reg ? wb_read_data : wb_alu_result;
         for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            if (e[36:32] == wb_rd) e[37] = 1'b0;
            exp_q[i] = e;
         end
      end
      if (curPop) begin
         e = exp_q.pop_front();
         if (e[37] && (e[36:32] != 5'd0)) modelRf[e[36:32]] = e[31:0];
      end
      if (mdu_valid && readyBefore) exp_q.push_back({1'b1, mdu_rd, mdu_data});
      if (curPop || (sizeBefore == 0)) begin
         blocked  = 0;
         stallExp = 1'b0;
      end else begin
         blocked++;
         stallExp = (blocked == MAX_WAIT);
         if (stallExp) blocked = 0;
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wbIdle();
      wb_valid      = 1'b0;
      wb_reg_write  = 1'b0;
      wb_mem_to_reg = 1'b0;
      wb_rd         = '0;
   endtask

   task automatic wbWrite(input logic [4:0] rd, input logic memSel,
                          input logic [SIZE-1:0] rdata, input logic [SIZE-1:0] alu);
      wb_valid      = 1'b1;
      wb_reg_write  = 1'b1;
      wb_mem_to_reg = memSel;
      wb_rd         = rd;
      wb_read_data  = rdata;
      wb_alu_result = alu;
   endtask

   task automatic mduOffer(input logic v, input logic [4:0] rd, input logic [SIZE-1:0] d);
      mdu_valid = v;
      mdu_rd    = rd;
      mdu_data  = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int wbPct;
      testCount = 0;
      failCount = 0;
      blocked   = 0;
      stallExp  = 1'b0;
      shWe      = 1'b0;
      shAddr    = '0;
      shData    = '0;
      curPipeWr = 1'b0;
      curPop    = 1'b0;
      for (int i = 0; i < 32; i++) begin
         modelRf[i]  = '0;
         shadowRf[i] = '0;
      end
      rst_n         = 1'b0;
      wb_read_data  = '0;
      wb_alu_result = '0;
      rs_addr       = '0;
      rt_addr       = '0;
      wbIdle();
      mduOffer(1'b0, 5'd0, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: idle after reset
      checkCycle("t1_idle");
      check("t1_we0", rf_we, 1'b0);
      check("t1_ready1", mdu_ready, 1'b1);
      check("t1_stall0", stall_pipe, 1'b0);
      advance();

      // 2: WB alone, both MemToReg selections, plus non-writing cases
      wbWrite(5'd8, 1'b1, 32'hDEADBEEF, 32'h77);
      checkCycle("t2_load");
      check("t2_load_waddr", rf_waddr, 5'd8);
      check("t2_load_wdata", rf_wdata, 32'hDEADBEEF);
      advance();
      wbWrite(5'd8, 1'b0, 32'hDEADBEEF, 32'h5);
      checkCycle("t2_alu");
      check("t2_alu_wdata", rf_wdata, 32'h5);
      advance();
      wbWrite(5'd0, 1'b0, 32'h0, 32'h99);
      checkCycle("t2_r0");
      check("t2_r0_we", rf_we, 1'b0);
      advance();
      wbIdle();

      // 3: single MDU result, one-cycle latency, pending flag
      rs_addr = 5'd3;
      mduOffer(1'b1, 5'd3, 32'h1234);
      checkCycle("t3_push");
      check("t3_push_pend", rs_pending, 1'b0);
      advance();
      mduOffer(1'b0, 5'd0, '0);
      checkCycle("t3_drain");
      check("t3_drain_pend", rs_pending, 1'b1);
      check("t3_drain_waddr", rf_waddr, 5'd3);
      check("t3_drain_wdata", rf_wdata, 32'h1234);
      advance();
      checkCycle("t3_after");
      check("t3_after_pend", rs_pending, 1'b0);
      advance();

      // 4: starvation forces a single stall cycle
      mduOffer(1'b1, 5'd10, 32'hA0A0);
      checkCycle("t4_c1");
      advance();
      mduOffer(1'b1, 5'd11, 32'hB0B0);
      wbWrite(5'd20, 1'b0, 32'h0, 32'h2020);
      checkCycle("t4_c2");
      advance();
      mduOffer(1'b0, 5'd0, '0);
      for (int i = 0; i < 3; i++) begin
         checkCycle("t4_block");
         check("t4_block_ready", mdu_ready, 1'b0);
         check("t4_block_stall", stall_pipe, 1'b0);
         advance();
      end
      mduOffer(1'b1, 5'd12, 32'hC0C0);
      checkCycle("t4_force");
      check("t4_force_stall", stall_pipe, 1'b1);
      check("t4_force_waddr", rf_waddr, 5'd10);
      check("t4_force_wdata", rf_wdata, 32'hA0A0);
      check("t4_force_ready", mdu_ready, 1'b0);
      advance();
      checkCycle("t4_after");
      check("t4_after_stall", stall_pipe, 1'b0);
      check("t4_after_waddr", rf_waddr, 5'd20);
      advance();
      mduOffer(1'b0, 5'd0, '0);
      wbIdle();
      repeat (3) begin
         checkCycle("t4_drain");
         advance();
      end
      check("t4_r11", shadowRf[11], 32'hB0B0);
      check("t4_r12", shadowRf[12], 32'hC0C0);

      // 5: WAW cancel by a younger pipeline write
      rs_addr = 5'd5;
      mduOffer(1'b1, 5'd5, 32'h5555);
      checkCycle("t5_push");
      advance();
      mduOffer(1'b0, 5'd0, '0);
      wbWrite(5'd5, 1'b0, 32'h0, 32'hAAAA);
      checkCycle("t5_wb");
      check("t5_wb_pend", rs_pending, 1'b1);
      advance();
      wbIdle();
      checkCycle("t5_dead");
      check("t5_dead_pend", rs_pending, 1'b0);
      check("t5_dead_we", rf_we, 1'b0);
      advance();
      checkCycle("t5_idle");
      advance();
      check("t5_r5", shadowRf[5], 32'hAAAA);

      // 6: r0 result, then reset with two results pending
      mduOffer(1'b1, 5'd0, 32'h0F0F);
      checkCycle("t6_r0push");
      advance();
      mduOffer(1'b0, 5'd0, '0);
      checkCycle("t6_r0pop");
      check("t6_r0pop_we", rf_we, 1'b0);
      advance();
      rt_addr = 5'd13;
      mduOffer(1'b1, 5'd12, 32'h1212);
      wbWrite(5'd20, 1'b0, 32'h0, 32'h2121);
      checkCycle("t6_p1");
      advance();
      mduOffer(1'b1, 5'd13, 32'h1313);
      checkCycle("t6_p2");
      advance();
      mduOffer(1'b0, 5'd0, '0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_we", rf_we, 1'b0);
      check("t6_rst_ready", mdu_ready, 1'b1);
      check("t6_rst_rtpend", rt_pending, 1'b0);
      check("t6_rst_stall", stall_pipe, 1'b0);
      exp_q.delete();
      blocked  = 0;
      stallExp = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wbIdle();
      rs_addr = 5'd12;
      repeat (3) begin
         checkCycle("t6_post");
         check("t6_post_we", rf_we, 1'b0);
         advance();
      end

      // Randomized traffic, alternating light and heavy WB pressure
      for (int cyc = 0; cyc < 1500; cyc++) begin
         wbPct         = ((cyc / 250) % 2 == 1) ? 92 : 40;
         wb_valid      = ($urandom_range(99) < wbPct);
         wb_reg_write  = ($urandom_range(9) != 0);
         wb_mem_to_reg = 1'($urandom_range(1));
         wb_rd         = 5'($urandom_range(7));
         wb_read_data  = $urandom;
         wb_alu_result = $urandom;
         mdu_valid     = ($urandom_range(99) < 50);
         mdu_rd        = 5'($urandom_range(7));
         mdu_data      = $urandom;
         rs_addr       = 5'($urandom_range(7));
         rt_addr       = 5'($urandom_range(7));
         checkCycle("rnd");
         advance();
      end
      wbIdle();
      mduOffer(1'b0, 5'd0, '0);
      repeat (DEPTH + 2) begin
         checkCycle("rnd_drain");
         advance();
      end

      // ---------------- final report ----------------
      for (int i = 0; i < 32; i++) begin
         check($sformatf("rf_r%0d", i), shadowRf[i], modelRf[i]);
      end
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
